// File: rtl/data_bus_pkg.sv
// data_bus_pkg: address map, button codes and the pending-mask priority helper
// shared by the data bus and its button-event FIFO.
package data_bus_pkg;

  localparam int unsigned RAM_SIZE = 240;
  localparam logic [7:0]  RAM_TOP  = 8'hEF;

  localparam logic [7:0] ADDR_EVT    = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_LED    = 8'hF2;
  localparam logic [7:0] ADDR_SEG_LO = 8'hF3;
  localparam logic [7:0] ADDR_SEG_HI = 8'hF4;
  localparam logic [7:0] ADDR_TIMER  = 8'hF5;

  localparam int unsigned NUM_BTN = 5;

  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_DOWN  = 3'd1,
    BTN_LEFT  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_SEL   = 3'd4
  } btnCode_e;

  // Index of the lowest set bit; lower button codes take priority.
  function automatic logic [2:0] lowestSet(input logic [NUM_BTN-1:0] mask);
    logic [2:0] code;
    code = BTN_UP;
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      if (mask[i-1]) code = 3'(i - 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// btn_event_fifo: small FIFO of 3-bit button codes with occupancy count and a
// sticky overflow flag. A push into a full FIFO is kept only when a pop
// frees a slot on the same edge; otherwise it is dropped and flags overflow.
module btn_event_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push,
  input  logic [2:0] pushCode,
  input  logic       pop,
  input  logic       clrOvf,
  output logic [2:0] head,
  output logic [3:0] count,
  output logic       empty,
  output logic       ovf
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [4:0]    cnt;
  logic          full;
  logic          doPop;
  logic          doPush;
  logic          drop;

  assign empty  = (cnt == 5'd0);
  assign full   = (cnt == 5'(FIFO_DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign drop   = push && full && !doPop;
  assign head   = mem[rdPtr];
  assign count  = cnt[3:0];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushCode;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
      ovf <= (ovf && !clrOvf) || drop;
    end
  end

endmodule

// File: rtl/data_bus.sv
// data_bus: CPU data-side address decoder serving a 240-byte RAM, a
// button-event FIFO and LED/seven-segment/timer registers. Reads are
// combinational from Addr; writes and pops commit on the rising edge.
// Optional timer at 0xF5 is built only when DATA_BUS_TIMER_EN is defined.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  Addr,
  input  logic [7:0]  WData,
  input  logic        MW,
  input  logic        RD,
  output logic [7:0]  Din,
  input  logic [4:0]  BTN,
  output logic [7:0]  LED,
  output logic [15:0] SEG
);

  logic [NUM_BTN-1:0] btnSync1;
  logic [NUM_BTN-1:0] btnSync2;
  logic [NUM_BTN-1:0] btnPrev;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] btnRise;
  logic [NUM_BTN-1:0] pendClr;
  logic               push;
  logic [2:0]         pushCode;
  logic               pop;
  logic               clrOvf;
  logic [2:0]         fifoHead;
  logic [3:0]         fifoCount;
  logic               fifoEmpty;
  logic               fifoOvf;
  logic [7:0]         ram [RAM_SIZE];
  logic [7:0]         ledReg;
  logic [7:0]         segLo;
  logic [7:0]         segHi;
  logic [7:0]         timerRd;

  assign btnRise  = btnSync2 & ~btnPrev;
  assign push     = |pending;
  assign pushCode = lowestSet(pending);
  assign pendClr  = push ? (5'b00001 << pushCode) : '0;
  assign pop      = RD && (Addr == ADDR_EVT);
  assign clrOvf   = MW && (Addr == ADDR_STATUS);
  assign LED      = ledReg;
  assign SEG      = {segHi, segLo};

  // Button synchronizers, edge history and pending-event mask.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      btnPrev  <= '0;
      pending  <= '0;
    end else begin
      btnSync1 <= BTN;
      btnSync2 <= btnSync1;
      btnPrev  <= btnSync2;
      // A fresh rise on the bit being drained this cycle stays pending.
      pending  <= (pending & ~pendClr) | btnRise;
    end
  end

  btn_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) uFifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .pushCode (pushCode),
    .pop      (pop),
    .clrOvf   (clrOvf),
    .head     (fifoHead),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .ovf      (fifoOvf)
  );

  // Data RAM write port (no reset).
  always_ff @(posedge CLK) begin
    if (MW && (Addr <= RAM_TOP)) ram[Addr] <= WData;
  end

  // LED and seven-segment registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ledReg <= '0;
      segLo  <= '0;
      segHi  <= '0;
    end else if (MW) begin
      if (Addr == ADDR_LED)    ledReg <= WData;
      if (Addr == ADDR_SEG_LO) segLo  <= WData;
      if (Addr == ADDR_SEG_HI) segHi  <= WData;
    end
  end

`ifdef DATA_BUS_TIMER_EN
  localparam int unsigned      PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic [7:0]       timerReg;
  logic             timerWr;

  assign timerWr = MW && (Addr == ADDR_TIMER);
  assign timerRd = timerReg;

  // Prescaled saturating timer; a write clears it even on a wrap edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prescaler <= '0;
      timerReg  <= '0;
    end else if (timerWr) begin
      prescaler <= '0;
      timerReg  <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      if (timerReg != 8'hFF) timerReg <= timerReg + 8'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end
`else
  assign timerRd = '0;
`endif

  // Read-data decode; RAM reads show the pre-write byte during a store.
  always_comb begin
    Din = '0;
    if (Addr <= RAM_TOP) begin
      Din = ram[Addr];
    end else begin
      case (Addr)
        ADDR_EVT:    Din = fifoEmpty ? 8'h00 : {1'b1, 4'b0000, fifoHead};
        ADDR_STATUS: Din = {fifoOvf, 3'b000, fifoCount};
        ADDR_LED:    Din = ledReg;
        ADDR_SEG_LO: Din = segLo;
        ADDR_SEG_HI: Din = segHi;
        ADDR_TIMER:  Din = timerRd;
        default:     Din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed scoreboard bench for data_bus (FIFO_DEPTH=4,
// TICK_DIV=4). Timer expectations follow DATA_BUS_TIMER_EN.
module tb_data_bus;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  Addr;
  logic [7:0]  WData;
  logic        MW;
  logic        RD;
  logic [7:0]  Din;
  logic [4:0]  BTN;
  logic [7:0]  LED;
  logic [15:0] SEG;

  data_bus #(
    .FIFO_DEPTH(4),
    .TICK_DIV  (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .Addr  (Addr),
    .WData (WData),
    .MW    (MW),
    .RD    (RD),
    .Din   (Din),
    .BTN   (BTN),
    .LED   (LED),
    .SEG   (SEG)
  );

  always #5 CLK = ~CLK;

  // kind: 0 = Din, 1 = LED, 2 = SEG
  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t       sb[$];
  int          nVec = 0;
  int          nErr = 0;
  item_t       mIt;
  logic [15:0] mAct;

  // Monitor: drains everything expected for the current cycle at negedge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      mIt = sb.pop_front();
      case (mIt.kind)
        0:       mAct = {8'h00, Din};
        1:       mAct = {8'h00, LED};
        default: mAct = SEG;
      endcase
      nVec++;
      if (mAct !== mIt.exp) begin
        nErr++;
        $display("FAIL %s: got %h expected %h", mIt.name, mAct, mIt.exp);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectV(input int kind, input logic [15:0] v, input string nm);
    item_t it;
    it.kind = kind;
    it.exp  = v;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic chkNow(input int kind, input logic [15:0] v, input string nm);
    logic [15:0] act;
    case (kind)
      0:       act = {8'h00, Din};
      1:       act = {8'h00, LED};
      default: act = SEG;
    endcase
    nVec++;
    if (act !== v) begin
      nErr++;
      $display("FAIL %s (immediate): got %h expected %h", nm, act, v);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    Addr  = a;
    WData = d;
    MW    = 1'b1;
    tick();
    MW    = 1'b0;
  endtask

  task automatic rdChk(input logic [7:0] a, input logic [7:0] v, input string nm);
    Addr = a;
    expectV(0, {8'h00, v}, nm);
    tick();
  endtask

  task automatic popChk(input logic [7:0] v, input string nm);
    Addr = 8'hF0;
    RD   = 1'b1;
    expectV(0, {8'h00, v}, nm);
    tick();
    RD   = 1'b0;
  endtask

  logic [7:0] tExp;

  initial begin
    RESET = 1'b1;
    Addr  = 8'h00;
    WData = 8'h00;
    MW    = 1'b0;
    RD    = 1'b0;
    BTN   = 5'b00000;
    tick();
    tick();
    // Reset state
    Addr = 8'hF1;
    #1;
    chkNow(0, 16'h0000, "rst_status_now");
    chkNow(1, 16'h0000, "rst_led_now");
    chkNow(2, 16'h0000, "rst_seg_now");
    expectV(0, 16'h0000, "rst_status");
    expectV(1, 16'h0000, "rst_led");
    expectV(2, 16'h0000, "rst_seg");
    tick();
    rdChk(8'hF0, 8'h00, "rst_evt");
    RESET = 1'b0;

    // Timer: TICK_DIV=4 -> 3 after 12 edges; write clears; saturates
    repeat (12) tick();
`ifdef DATA_BUS_TIMER_EN
    tExp = 8'h03;
`else
    tExp = 8'h00;
`endif
    rdChk(8'hF5, tExp, "timer_12");
    wr(8'hF5, 8'h55);
    rdChk(8'hF5, 8'h00, "timer_clr");
    repeat (1100) tick();
`ifdef DATA_BUS_TIMER_EN
    tExp = 8'hFF;
`else
    tExp = 8'h00;
`endif
    rdChk(8'hF5, tExp, "timer_sat");

    // RAM
    wr(8'h10, 8'hA5);
    rdChk(8'h10, 8'hA5, "ram_wr");
    Addr  = 8'h10;
    WData = 8'h5A;
    MW    = 1'b1;
    expectV(0, 16'h00A5, "ram_rd_old");
    tick();
    MW = 1'b0;
    rdChk(8'h10, 8'h5A, "ram_rd_new");
    wr(8'hEF, 8'h77);
    rdChk(8'hEF, 8'h77, "ram_top");
    wr(8'hF0, 8'hFF);
    rdChk(8'hF0, 8'h00, "evt_wr_ign");
    wr(8'hF6, 8'h99);
    rdChk(8'hF6, 8'h00, "unmapped");

    // LED / SEG
    wr(8'hF2, 8'h3C);
    Addr = 8'hF2;
    expectV(0, 16'h003C, "led_rd");
    expectV(1, 16'h003C, "led_out");
    tick();
    wr(8'hF3, 8'h34);
    wr(8'hF4, 8'h12);
    Addr = 8'hF4;
    expectV(0, 16'h0012, "seghi_rd");
    expectV(2, 16'h1234, "seg_out");
    tick();

    // Single event latency: BTN[2] first sampled at edge k
    BTN = 5'b00100;
    tick();                         // k
    tick();                         // k+1
    BTN = 5'b00000;
    tick();                         // k+2: pending set, not pushed
    rdChk(8'hF1, 8'h00, "lat_k2");  // edge k+3 pushes
    rdChk(8'hF1, 8'h01, "lat_k3");
    rdChk(8'hF0, 8'h82, "evt_left");
    popChk(8'h82, "pop_left");
    rdChk(8'hF0, 8'h00, "evt_empty");
    rdChk(8'hF1, 8'h00, "cnt_zero");
    popChk(8'h00, "pop_empty");
    rdChk(8'hF1, 8'h00, "pop_empty_cnt");

    // Simultaneous rises: code 0 then code 4, no repeats while held
    BTN = 5'b10001;
    repeat (3) tick();
    rdChk(8'hF1, 8'h00, "sim_k2");
    rdChk(8'hF1, 8'h01, "sim_k3");
    rdChk(8'hF1, 8'h02, "sim_k4");
    repeat (4) tick();
    rdChk(8'hF1, 8'h02, "held_norep");
    popChk(8'h80, "sim_pop0");
    popChk(8'h84, "sim_pop4");
    rdChk(8'hF0, 8'h00, "sim_empty");
    BTN = 5'b00000;
    repeat (3) tick();

    // Overflow: five rises into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      BTN[i] = 1'b1;
      repeat (4) tick();
    end
    rdChk(8'hF1, 8'h84, "ovf_status");
    rdChk(8'hF0, 8'h80, "ovf_head");
    wr(8'hF1, 8'h00);
    rdChk(8'hF1, 8'h04, "ovf_clr");
    BTN = 5'b00000;
    repeat (3) tick();
    // Push and pop on the same edge while full
    BTN = 5'b00001;
    repeat (3) tick();
    popChk(8'h80, "full_pushpop");
    rdChk(8'hF1, 8'h04, "full_pp_cnt");
    popChk(8'h81, "wrap_pop1");
    popChk(8'h82, "wrap_pop2");
    popChk(8'h83, "wrap_pop3");
    popChk(8'h80, "wrap_pop0");
    rdChk(8'hF1, 8'h00, "wrap_empty");

    // Asynchronous reset with two events queued and LED=0xFF
    wr(8'hF2, 8'hFF);
    BTN = 5'b00111;
    repeat (5) tick();
    Addr = 8'hF1;
    expectV(0, 16'h0002, "pre_rst_cnt");
    expectV(1, 16'h00FF, "pre_rst_led");
    tick();
    #2;
    RESET = 1'b1;
    BTN   = 5'b00000;
    Addr  = 8'hF1;
    #1;
    chkNow(0, 16'h0000, "arst_status_now");
    chkNow(1, 16'h0000, "arst_led_now");
    expectV(0, 16'h0000, "arst_status");
    expectV(1, 16'h0000, "arst_led");
    expectV(2, 16'h0000, "arst_seg");
    tick();
    tick();
    RESET = 1'b0;
    rdChk(8'hF0, 8'h00, "post_rst_evt");
    rdChk(8'hF1, 8'h00, "post_rst_status");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
